lcd_i2c_feeder: RTL and testbench

Upstream stage of the I2C LCD master: turns HD44780 command/data bytes into the PCF8574 backpack byte stream (4-bit mode, EN strobing, backlight bit) and hands each byte to the I2C byte-write master over a valid/ready handshake. On reset exit it autonomously runs the HD44780 power-up/4-bit init sequence. It also enforces controller execution delays, so the LCD never sees a command while busy.

---
 rtl/lcd_i2c_feeder.sv | 204 ++++++++++++++++++++
 tb/tb_lcd_i2c_feeder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_i2c_feeder.sv
// HD44780-over-PCF8574 byte feeder: runs the 4-bit power-up init, then turns host
// command/data bytes into EN-strobed backpack bytes for the I2C byte-write master.
module lcd_i2c_feeder #(
    parameter int unsigned POWERUP_WAIT = 2_000_000,
    parameter int unsigned LONG_WAIT    = 100_000,
    parameter int unsigned CMD_WAIT     = 2_500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_rs,
    input  logic       bl,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       init_done
);

    typedef enum logic [2:0] {PWRUP, INIT_SEND, INIT_WAIT, IDLE, SEND, WAIT} state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       nibble;
        logic       long_wait;
    } unit_t;

    localparam logic [20:0] PWRUP_LAST = 21'(POWERUP_WAIT - 1);
    localparam logic [20:0] LONG_LAST  = 21'(LONG_WAIT - 1);
    localparam logic [20:0] CMD_LAST   = 21'(CMD_WAIT - 1);
    localparam logic [2:0]  ROM_LAST   = 3'd7;

    // Nibble units carry their nibble in data[7:4] and stop after the high half.
    function automatic unit_t rom_entry(input logic [2:0] idx);
        unit_t u;
        case (idx)
            3'd0:    u = '{data: 8'h30, nibble: 1'b1, long_wait: 1'b1};
            3'd1:    u = '{data: 8'h30, nibble: 1'b1, long_wait: 1'b0};
            3'd2:    u = '{data: 8'h30, nibble: 1'b1, long_wait: 1'b0};
            3'd3:    u = '{data: 8'h20, nibble: 1'b1, long_wait: 1'b0};
            3'd4:    u = '{data: 8'h28, nibble: 1'b0, long_wait: 1'b0};
            3'd5:    u = '{data: 8'h0C, nibble: 1'b0, long_wait: 1'b0};
            3'd6:    u = '{data: 8'h01, nibble: 1'b0, long_wait: 1'b1};
            default: u = '{data: 8'h06, nibble: 1'b0, long_wait: 1'b0};
        endcase
        return u;
    endfunction

    // Backpack byte {D7..D4, BL, EN, RW, RS}; even sub-bytes raise EN, odd ones drop it.
    function automatic logic [7:0] sub_byte(input logic [7:0] data, input logic rs,
                                            input logic bl_en, input logic [1:0] idx);
        logic [3:0] nib;
        nib = idx[1] ? data[3:0] : data[7:4];
        return {nib, bl_en, ~idx[0], 1'b0, rs};
    endfunction

    state_t      state_q, state_d;
    logic [20:0] cnt_q, cnt_d;
    logic [2:0]  rom_idx_q, rom_idx_d;
    logic [1:0]  sub_q, sub_d;
    logic [1:0]  last_q, last_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        bl_q, bl_d;
    logic        long_q, long_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        in_ready_q, in_ready_d;
    logic        init_done_q, init_done_d;

    logic        load;
    logic        load_rs;
    unit_t       load_unit;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        rom_idx_d   = rom_idx_q;
        sub_d       = sub_q;
        last_d      = last_q;
        data_d      = data_q;
        rs_d        = rs_q;
        bl_d        = bl_q;
        long_d      = long_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        in_ready_d  = in_ready_q;
        init_done_d = init_done_q;
        load        = 1'b0;
        load_rs     = 1'b0;
        load_unit   = '0;

        case (state_q)
            PWRUP: begin
                if (cnt_q == PWRUP_LAST) begin
                    cnt_d     = '0;
                    rom_idx_d = 3'd0;
                    load      = 1'b1;
                    load_unit = rom_entry(3'd0);
                    state_d   = INIT_SEND;
                end else begin
                    cnt_d = cnt_q + 21'd1;
                end
            end
            INIT_SEND, SEND: begin
                if (out_valid_q && out_ready) begin
                    if (sub_q == last_q) begin
                        out_valid_d = 1'b0;
                        cnt_d       = long_q ? LONG_LAST : CMD_LAST;
                        state_d     = (state_q == SEND) ? WAIT : INIT_WAIT;
                    end else begin
                        sub_d      = sub_q + 2'd1;
                        out_data_d = sub_byte(data_q, rs_q, bl_q, sub_q + 2'd1);
                    end
                end
            end
            INIT_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 21'd1;
                end else if (rom_idx_q == ROM_LAST) begin
                    init_done_d = 1'b1;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    rom_idx_d = rom_idx_q + 3'd1;
                    load      = 1'b1;
                    load_unit = rom_entry(rom_idx_q + 3'd1);
                    state_d   = INIT_SEND;
                end
            end
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    in_ready_d = 1'b0;
                    load       = 1'b1;
                    load_rs    = in_rs;
                    load_unit  = '{data: in_data, nibble: 1'b0,
                                   long_wait: !in_rs && (in_data == 8'h01 || in_data == 8'h02)};
                    state_d    = SEND;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 21'd1;
                end else begin
                    in_ready_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = PWRUP;
        endcase

        // Backlight is sampled here, at unit start, so idle bl changes stay off the bus.
        if (load) begin
            data_d      = load_unit.data;
            rs_d        = load_rs;
            bl_d        = bl;
            last_d      = load_unit.nibble ? 2'd1 : 2'd3;
            long_d      = load_unit.long_wait;
            sub_d       = 2'd0;
            out_valid_d = 1'b1;
            out_data_d  = sub_byte(load_unit.data, load_rs, bl, 2'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= PWRUP;
            cnt_q       <= '0;
            rom_idx_q   <= '0;
            sub_q       <= '0;
            last_q      <= '0;
            data_q      <= '0;
            rs_q        <= 1'b0;
            bl_q        <= 1'b0;
            long_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rom_idx_q   <= rom_idx_d;
            sub_q       <= sub_d;
            last_q      <= last_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            bl_q        <= bl_d;
            long_q      <= long_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            init_done_q <= init_done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign in_ready  = in_ready_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_lcd_i2c_feeder.sv
// Directed bench for lcd_i2c_feeder with shortened waits (100/20/5 cycles).
module tb_lcd_i2c_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_rs;
    logic       bl;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       init_done;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    lcd_i2c_feeder #(
        .POWERUP_WAIT(100),
        .LONG_WAIT   (20),
        .CMD_WAIT    (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_rs    (in_rs),
        .bl       (bl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .init_done(init_done)
    );

    // Init stream with bl=1, and the idle gap expected before each byte.
    logic [7:0] init_bytes [24] = '{
        8'h3C, 8'h38, 8'h3C, 8'h38, 8'h3C, 8'h38, 8'h2C, 8'h28,
        8'h2C, 8'h28, 8'h8C, 8'h88, 8'h0C, 8'h08, 8'hCC, 8'hC8,
        8'h0C, 8'h08, 8'h1C, 8'h18, 8'h0C, 8'h08, 8'h6C, 8'h68
    };
    int init_gaps [24] = '{
        100, 0, 20, 0, 5, 0, 5, 0,
        5, 0, 0, 0, 5, 0, 0, 0,
        5, 0, 0, 0, 20, 0, 0, 0
    };

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; waits for out_valid, takes the byte, and steps past its accept edge.
    task automatic get_byte(output logic [7:0] b, output int gap);
        gap = 0;
        while (!out_valid && gap < 1000) begin
            @(negedge clk);
            gap++;
        end
        b = out_data;
        @(negedge clk);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_init();
        logic [7:0] b;
        int gap;
        int n;
        for (int i = 0; i < 24; i++) begin
            get_byte(b, gap);
            check($sformatf("init byte %0d", i), {24'h0, b}, {24'h0, init_bytes[i]});
            check($sformatf("init gap %0d", i), gap, init_gaps[i]);
        end
        n = 0;
        while (!init_done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("init_done delay", n, 5);
        check("in_ready with init_done", {31'h0, in_ready}, 32'h1);
    endtask

    task automatic send_host(input logic [7:0] d, input logic rs, input logic b);
        in_valid = 1'b1;
        in_data  = d;
        in_rs    = rs;
        bl       = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_unit(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp [4];
        logic [7:0] b;
        int gap;
        exp = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            get_byte(b, gap);
            check($sformatf("%s byte %0d", tag, i), {24'h0, b}, {24'h0, exp[i]});
            check($sformatf("%s gap %0d", tag, i), gap, 0);
        end
    endtask

    initial begin
        int n;
        int stable;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_rs     = 1'b0;
        bl        = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset out_valid", {31'h0, out_valid}, 32'h0);
        check("reset out_data", {24'h0, out_data}, 32'h0);
        check("reset in_ready", {31'h0, in_ready}, 32'h0);
        check("reset init_done", {31'h0, init_done}, 32'h0);

        rst = 1'b1;
        run_init();

        // Character 'A'
        send_host(8'h41, 1'b1, 1'b1);
        check("host latency A", {31'h0, out_valid}, 32'h1);
        check("in_ready drop A", {31'h0, in_ready}, 32'h0);
        expect_unit("data A", 8'h4D, 8'h49, 8'h1D, 8'h19);
        wait_ready(n);
        check("wait after A", n, 5);

        // Backlight toggled while idle must not cause traffic
        bl = 1'b0;
        repeat (5) @(negedge clk);
        check("bl idle no traffic", {31'h0, out_valid}, 32'h0);

        // Clear display with backlight off
        send_host(8'h01, 1'b0, 1'b0);
        expect_unit("clear", 8'h04, 8'h00, 8'h14, 8'h10);
        wait_ready(n);
        check("wait after clear", n, 20);

        // Backpressure on 'A'
        out_ready = 1'b0;
        send_host(8'h41, 1'b1, 1'b1);
        stable = 0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid && out_data == 8'h4D) stable++;
            @(negedge clk);
        end
        check("backpressure stable", stable, 50);
        out_ready = 1'b1;
        expect_unit("backpressure", 8'h4D, 8'h49, 8'h1D, 8'h19);
        wait_ready(n);
        check("wait after backpressure", n, 5);

        // Reset in the middle of a unit
        out_ready = 1'b0;
        send_host(8'h48, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid reset out_valid", {31'h0, out_valid}, 32'h0);
        check("mid reset init_done", {31'h0, init_done}, 32'h0);
        check("mid reset in_ready", {31'h0, in_ready}, 32'h0);
        check("mid reset out_data", {24'h0, out_data}, 32'h0);
        out_ready = 1'b1;
        bl        = 1'b1;
        rst       = 1'b1;
        run_init();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
